updown_sweep_ctrl: RTL

- Sequencer for the team's 8-bit up/down counter (load/direction/data_in control pins).
- On `start`, it loads the counter with a low limit, then runs a triangle sweep: up to a high limit, back down to the low limit.
- Repeats for a programmed number of sweeps, then parks the counter at the low limit.
- The counter advances on every non-load cycle, so this block holds it by reloading its current value; a shadow position register tracks the counter's internal value.

---
 rtl/updown_sweep_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer for the 8-bit up/down counter: load lo, ramp to hi, ramp back, repeat num times.
// Optional SWEEP_PAUSE_EN adds a pause input that freezes UP/DOWN by reloading the current position.
module updown_sweep_ctrl #(
  parameter int WIDTH   = 8,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
`ifdef SWEEP_PAUSE_EN
  input  logic               pause,
`endif
  input  logic [WIDTH-1:0]   lo_limit,
  input  logic [WIDTH-1:0]   hi_limit,
  input  logic [SWEEP_W-1:0] num_sweeps,
  output logic               ctr_load,
  output logic               ctr_dir,
  output logic [WIDTH-1:0]   ctr_data,
  output logic [WIDTH-1:0]   pos,
  output logic [SWEEP_W-1:0] sweep_cnt,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               error
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_UP, S_DOWN, S_DONE} state_t;

  localparam logic [WIDTH-1:0]   POS_ONE = 1;
  localparam logic [SWEEP_W-1:0] CNT_ONE = 1;

  state_t             r_state;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic [SWEEP_W-1:0] r_num;

  logic [WIDTH-1:0]   w_pos_up;
  logic [WIDTH-1:0]   w_pos_dn;
  logic [SWEEP_W-1:0] w_cnt_inc;
  logic               w_paused;

  assign w_pos_up  = pos + POS_ONE;
  assign w_pos_dn  = pos - POS_ONE;
  assign w_cnt_inc = sweep_cnt + CNT_ONE;

  // abort overrides pause so the counter still takes the step on the abort edge
`ifdef SWEEP_PAUSE_EN
  assign w_paused = pause && !abort && (r_state == S_UP || r_state == S_DOWN);
`else
  assign w_paused = 1'b0;
`endif

  always_comb begin
    ctr_load = 1'b1;
    ctr_dir  = 1'b1;
    ctr_data = pos;
    busy     = 1'b0;
    case (r_state)
      S_LOAD: begin
        ctr_data = r_lo;
        busy     = 1'b1;
      end
      S_UP: begin
        ctr_load = w_paused;
        busy     = 1'b1;
      end
      S_DOWN: begin
        ctr_load = w_paused;
        ctr_dir  = 1'b0;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_lo      <= '0;
      r_hi      <= '0;
      r_num     <= '0;
      pos       <= '0;
      sweep_cnt <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      error     <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      error   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            if (lo_limit < hi_limit && num_sweeps != '0) begin
              r_lo      <= lo_limit;
              r_hi      <= hi_limit;
              r_num     <= num_sweeps;
              sweep_cnt <= '0;
              r_state   <= S_LOAD;
            end else begin
              error <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          pos <= r_lo;
          if (abort) begin
            aborted <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_UP;
          end
        end
        S_UP: begin
          if (!w_paused) pos <= w_pos_up;
          if (abort) begin
            aborted <= 1'b1;
            r_state <= S_IDLE;
          end else if (!w_paused && w_pos_up == r_hi) begin
            r_state <= S_DOWN;
          end
        end
        S_DOWN: begin
          if (!w_paused) pos <= w_pos_dn;
          if (abort) begin
            aborted <= 1'b1;
            r_state <= S_IDLE;
          end else if (!w_paused && w_pos_dn == r_lo) begin
            sweep_cnt <= w_cnt_inc;
            if (w_cnt_inc == r_num) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_UP;
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
